// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the 3-stage RV32I hazard controller:
//   - RV32I major opcodes used by the hazard rules
//   - default bubble encoding (addi x0,x0,0)
//   - ALU operand / store-data select encodings
//   - decoded-instruction flag bundle produced by inst_decode
// Optional feature macro used by the importing files: HAZARD_FWD_EN.
package hazard_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Operand select encodings shared by a_sel, b_sel and rs2_fwd.
   typedef enum logic [1:0] {
      SEL_REG     = 2'b00,
      SEL_PC_IMM  = 2'b01,
      SEL_FWD_ALU = 2'b10,
      SEL_FWD_LD  = 2'b11
   } sel_t;

   // Per-instruction flags needed by the hazard rules.
   typedef struct packed {
      logic wr;         // writes a non-x0 destination
      logic use1;       // reads rs1
      logic use2;       // reads rs2
      logic is_load;
      logic is_store;
      logic is_branch;
      logic is_ctrl;    // JAL, JALR or BRANCH
      logic is_op;      // register-register ALU op (no immediate)
      logic pc_src;     // ALU A operand is the PC (AUIPC, JAL, BRANCH)
   } dec_t;

   // Forwarding source depends on whether the producer in WB is a load.
   function automatic sel_t fwd_code(input logic from_load);
      return from_load ? SEL_FWD_LD : SEL_FWD_ALU;
   endfunction

endpackage

// File: rtl/hazard_ctrl_inst_decode.sv
// inst_decode
// Combinational decoder reducing a 32-bit RV32I word to the flags the
// hazard controller needs. Instantiated once for the EX word and once for
// the WB word.
// Ports:
//   inst  in  32  instruction word
//   dec   out     decoded flag bundle (hazard_ctrl_pkg::dec_t)
module inst_decode
   import hazard_ctrl_pkg::*;
(
   input  logic [31:0] inst,
   output dec_t        dec
);

   logic [6:0] opc;
   assign opc = inst[6:0];

   // NOTE: combinational blocks assign every output up front so no path
   // can leave a value unassigned and infer a latch.
   always_comb begin
      dec           = '0;
      dec.is_load   = (opc == OPC_LOAD);
      dec.is_store  = (opc == OPC_STORE);
      dec.is_branch = (opc == OPC_BRANCH);
      dec.is_op     = (opc == OPC_OP);
      dec.is_ctrl   = (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
      dec.pc_src    = (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_BRANCH);
      dec.wr        = !dec.is_branch && !dec.is_store && (inst[11:7] != 5'd0);
      dec.use1      = (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL);
      dec.use2      = dec.is_op || dec.is_store || dec.is_branch;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for the IF/EX/WB RV32I core. Owns the EX
// (hold) and WB instruction registers, detects RAW hazards between EX and
// WB, and drives operand selects, PC stall/redirect and bubble insertion.
// Build option: define HAZARD_FWD_EN to forward WB results into EX; without
// it a RAW hazard stalls EX for one cycle instead.
// Ports:
//   clk         in   1      clock
//   rst         in   1      synchronous active-high reset
//   inst_f      in   32     IMEM output, valid in EX
//   br_taken    in   1      branch comparator result for inst_x
//   mem_stall   in   1      external freeze; all state holds
//   inst_x      out  32     effective EX instruction
//   inst_w      out  32     WB instruction
//   pc_stall    out  1      hold PC and IF
//   pc_sel      out  1      1 selects the ALU target as next PC
//   a_sel       out  2      ALU A select (rs1 / PC / WB ALU / WB load)
//   b_sel       out  2      ALU B select (rs2 / imm / WB ALU / WB load)
//   rs2_fwd     out  2      store-data / compare rs2 source
//   bubble_cnt  out  CNT_W  saturating count of inserted bubbles
module hazard_ctrl #(
   parameter logic [31:0] NOP_INST = hazard_ctrl_pkg::NOP_INST,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst_f,
   input  logic             br_taken,
   input  logic             mem_stall,
   output logic [31:0]      inst_x,
   output logic [31:0]      inst_w,
   output logic             pc_stall,
   output logic             pc_sel,
   output logic [1:0]       a_sel,
   output logic [1:0]       b_sel,
   output logic [1:0]       rs2_fwd,
   output logic [CNT_W-1:0] bubble_cnt
);

   import hazard_ctrl_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [31:0] hold_inst;
   logic        hold_v;
   logic        kill;
   dec_t        dec_x;
   dec_t        dec_w;
   logic        haz1;
   logic        haz2;
   logic        raw_stall;
   logic        redirect;

   // A killed slot wins over a held one: after a redirect the held word
   // (if any) belongs to the wrong path.
   assign inst_x = kill ? NOP_INST : (hold_v ? hold_inst : inst_f);

   inst_decode u_dec_x (.inst(inst_x), .dec(dec_x));
   inst_decode u_dec_w (.inst(inst_w), .dec(dec_w));

   assign haz1 = dec_w.wr && dec_x.use1 && (inst_x[19:15] == inst_w[11:7]);
   assign haz2 = dec_w.wr && dec_x.use2 && (inst_x[24:20] == inst_w[11:7]);

`ifdef HAZARD_FWD_EN
   assign raw_stall = 1'b0;
`else
   // One stall cycle suffices: the producer retires from WB (regfile write)
   // while the consumer waits in the hold register.
   assign raw_stall = haz1 || haz2;
`endif

   assign redirect = dec_x.is_ctrl && (!dec_x.is_branch || br_taken)
                     && !raw_stall && !mem_stall;
   assign pc_sel   = redirect;
   assign pc_stall = raw_stall || mem_stall;

   always_comb begin
      a_sel   = dec_x.pc_src ? SEL_PC_IMM : SEL_REG;
      b_sel   = dec_x.is_op  ? SEL_REG    : SEL_PC_IMM;
      rs2_fwd = SEL_REG;
`ifdef HAZARD_FWD_EN
      if (haz1)
         a_sel = fwd_code(dec_w.is_load);
      if (haz2 && dec_x.is_op)
         b_sel = fwd_code(dec_w.is_load);
      if (haz2 && (dec_x.is_store || dec_x.is_branch))
         rs2_fwd = fwd_code(dec_w.is_load);
`endif
   end

   // NOTE: registers are written with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_w     <= NOP_INST;
         hold_v     <= 1'b0;
         kill       <= 1'b1;   // IMEM output is not valid in the first cycle
         bubble_cnt <= '0;
      end else if (!mem_stall) begin
         if (raw_stall) begin
            inst_w <= NOP_INST;
            hold_v <= 1'b1;
         end else begin
            inst_w <= inst_x;
            hold_v <= 1'b0;
            kill   <= redirect;
         end
         if ((raw_stall || kill) && (bubble_cnt != CNT_MAX))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   // NOTE: hold_inst is pure data qualified by hold_v, so it is left out of
   // reset; its contents are never observed until hold_v is set.
   always_ff @(posedge clk) begin
      if (!rst && !mem_stall && raw_stall)
         hold_inst <= inst_x;
   end

   // Not every decoded flag is consumed in every build.
   logic unused_dec;
   assign unused_dec = ^{dec_x, dec_w};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. A behavioural model derived from the
// pipeline rules is compared against the DUT on every cycle; a set of
// hand-computed literal expectations pins the model. Works in both builds
// (HAZARD_FWD_EN defined or not).
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int          CW  = 4;
   localparam logic [31:0] NOP = NOP_INST;
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int CMAX = (1 << CW) - 1;

   // Directed instruction words.
   localparam logic [31:0] ADDI1  = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] ADD2   = 32'h0010_8133; // add  x2,x1,x1
   localparam logic [31:0] LW3    = 32'h0000_2183; // lw   x3,0(x0)
   localparam logic [31:0] SW3    = 32'h0030_2223; // sw   x3,4(x0)
   localparam logic [31:0] BEQ    = 32'h0020_8463; // beq  x1,x2,8
   localparam logic [31:0] JAL1   = 32'h0100_00EF; // jal  x1,16
   localparam logic [31:0] ADDIX0 = 32'h0010_0013; // addi x0,x0,1
   localparam logic [31:0] ADD5   = 32'h0000_02B3; // add  x5,x0,x0

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   inst_f;
   logic          br_taken;
   logic          mem_stall;
   logic [31:0]   inst_x;
   logic [31:0]   inst_w;
   logic          pc_stall;
   logic          pc_sel;
   logic [1:0]    a_sel;
   logic [1:0]    b_sel;
   logic [1:0]    rs2_fwd;
   logic [CW-1:0] bubble_cnt;

   int checks = 0;
   int passes = 0;

   hazard_ctrl #(.NOP_INST(NOP), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .inst_f(inst_f), .br_taken(br_taken),
      .mem_stall(mem_stall), .inst_x(inst_x), .inst_w(inst_w),
      .pc_stall(pc_stall), .pc_sel(pc_sel), .a_sel(a_sel), .b_sel(b_sel),
      .rs2_fwd(rs2_fwd), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s got=%h want=%h", name, got, want);
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_w;
   logic [31:0] m_held;
   bit          m_held_v;
   bit          m_kill;
   int          m_cnt;
   bit          m_valid = 1'b0;

   function automatic bit writes(input logic [31:0] i);
      return !(i[6:0] inside {OPC_BRANCH, OPC_STORE}) && (i[11:7] != 0);
   endfunction
   function automatic bit reads1(input logic [31:0] i);
      return !(i[6:0] inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
   endfunction
   function automatic bit reads2(input logic [31:0] i);
      return i[6:0] inside {OPC_OP, OPC_STORE, OPC_BRANCH};
   endfunction

   function automatic logic [31:0] ex_now();
      if (m_kill) return NOP;
      if (m_held_v) return m_held;
      return inst_f;
   endfunction
   function automatic bit h1_now();
      logic [31:0] e = ex_now();
      return writes(m_w) && reads1(e) && (e[19:15] == m_w[11:7]);
   endfunction
   function automatic bit h2_now();
      logic [31:0] e = ex_now();
      return writes(m_w) && reads2(e) && (e[24:20] == m_w[11:7]);
   endfunction
   function automatic bit stall_now();
      return !FWD && (h1_now() || h2_now());
   endfunction
   function automatic bit redirect_now();
      logic [31:0] e = ex_now();
      bit xfer = (e[6:0] == OPC_JAL) || (e[6:0] == OPC_JALR)
                 || ((e[6:0] == OPC_BRANCH) && br_taken);
      return xfer && !stall_now() && !mem_stall;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_w      <= NOP;
         m_held_v <= 1'b0;
         m_kill   <= 1'b1;
         m_cnt    <= 0;
         m_valid  <= 1'b1;
      end else if (m_valid && !mem_stall) begin
         if (stall_now()) begin
            m_w      <= NOP;
            m_held   <= ex_now();
            m_held_v <= 1'b1;
         end else begin
            m_w      <= ex_now();
            m_held_v <= 1'b0;
            m_kill   <= redirect_now();
         end
         if (stall_now() || m_kill)
            m_cnt <= (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      end
   end

   always @(negedge clk) begin : compare
      logic [31:0] e;
      logic [1:0]  src, ea, eb, er;
      if (m_valid) begin
         e   = ex_now();
         src = (m_w[6:0] == OPC_LOAD) ? 2'b11 : 2'b10;
         ea  = (FWD && h1_now()) ? src
             : (e[6:0] inside {OPC_AUIPC, OPC_JAL, OPC_BRANCH}) ? 2'b01 : 2'b00;
         eb  = (e[6:0] != OPC_OP) ? 2'b01
             : (FWD && h2_now()) ? src : 2'b00;
         er  = (FWD && h2_now() && (e[6:0] inside {OPC_STORE, OPC_BRANCH})) ? src : 2'b00;
         check("m_inst_x",   inst_x,   e);
         check("m_inst_w",   inst_w,   m_w);
         check("m_pc_stall", pc_stall, stall_now() || mem_stall);
         check("m_pc_sel",   pc_sel,   redirect_now());
         check("m_a_sel",    a_sel,    ea);
         check("m_b_sel",    b_sel,    eb);
         check("m_rs2_fwd",  rs2_fwd,  er);
         check("m_bubble",   bubble_cnt, m_cnt);
      end
   end

   // ---------------- directed stimulus ----------------
   // Apply inputs just after a rising edge, return just after the falling
   // edge so literal checks see settled outputs for that cycle.
   task automatic cyc(input logic [31:0] i, input bit br, input bit ms);
      @(posedge clk); #1;
      inst_f = i; br_taken = br; mem_stall = ms;
      @(negedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; inst_f = NOP; br_taken = 1'b0; mem_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; inst_f = ADDI1;
      @(negedge clk); #1;
      // first cycle after reset: killed slot, nothing counted yet
      check("rst_inst_x", inst_x, NOP);
      check("rst_inst_w", inst_w, NOP);
      check("rst_bubble", bubble_cnt, 0);
      check("rst_pc_stall", pc_stall, 0);

      cyc(ADDI1, 0, 0);
      check("c1_inst_x", inst_x, ADDI1);
      check("c1_bubble", bubble_cnt, 1);
      check("c1_b_sel", b_sel, 2'b01);

      cyc(ADD2, 0, 0);                 // RAW on x1
`ifdef HAZARD_FWD_EN
      check("alu_fwd_a", a_sel, 2'b10);
      check("alu_fwd_b", b_sel, 2'b10);
      check("alu_fwd_stall", pc_stall, 0);
`else
      check("raw_stall", pc_stall, 1);
      check("raw_a_sel", a_sel, 2'b00);
      check("raw_b_sel", b_sel, 2'b00);
`endif

      cyc(ADD2, 0, 0);
`ifdef HAZARD_FWD_EN
      check("c3_inst_w", inst_w, ADD2);
      check("c3_bubble", bubble_cnt, 1);
`else
      check("c3_inst_w_nop", inst_w, NOP);
      check("c3_replay", inst_x, ADD2);
      check("c3_stall_clear", pc_stall, 0);
      check("c3_bubble", bubble_cnt, 2);
`endif

      cyc(LW3, 0, 0);
      cyc(SW3, 0, 0);                  // store data depends on the load
      check("ld_a_sel", a_sel, 2'b00);
      check("ld_b_sel", b_sel, 2'b01);
`ifdef HAZARD_FWD_EN
      check("ld_rs2_fwd", rs2_fwd, 2'b11);
      check("ld_stall", pc_stall, 0);
`else
      check("ld_rs2_fwd", rs2_fwd, 2'b00);
      check("ld_stall", pc_stall, 1);
`endif
      cyc(SW3, 0, 0);

      cyc(BEQ, 1, 0);                  // taken branch
      check("br_pc_sel", pc_sel, 1);
      check("br_a_sel", a_sel, 2'b01);
      cyc(ADDI1, 0, 0);                // wrong-path fetch
      check("br_bubble_x", inst_x, NOP);
      check("br_bubble_sel", pc_sel, 0);
      cyc(BEQ, 0, 0);                  // not-taken branch
      check("nt_pc_sel", pc_sel, 0);
      cyc(ADDIX0, 0, 0);
      check("nt_no_bubble", inst_x, ADDIX0);
      check("nt_bubble", bubble_cnt, FWD ? 2 : 4);

      cyc(ADD5, 0, 0);                 // reads x0 after a write to x0
      check("x0_stall", pc_stall, 0);
      check("x0_a_sel", a_sel, 2'b00);
      check("x0_b_sel", b_sel, 2'b00);

      for (int k = 0; k < 3; k++) begin
         cyc(JAL1, 0, 1);              // frozen JAL
         check("frz_pc_sel", pc_sel, 0);
         check("frz_pc_stall", pc_stall, 1);
         check("frz_inst_w", inst_w, ADD5);
         check("frz_bubble", bubble_cnt, FWD ? 2 : 4);
      end
      cyc(JAL1, 0, 0);
      check("jal_pc_sel", pc_sel, 1);
      cyc(ADDI1, 0, 0);
      check("jal_bubble_x", inst_x, NOP);
      cyc(ADDI1, 0, 0);
      check("jal_bubble", bubble_cnt, FWD ? 3 : 5);

      // back-to-back JALs: one bubble per two cycles, saturating at CMAX
      for (int k = 0; k < 32; k++) cyc(JAL1, 0, 0);
      cyc(ADDI1, 0, 0);
      check("sat_bubble", bubble_cnt, CMAX);
      cyc(ADDI1, 0, 0);
      check("sat_hold", bubble_cnt, CMAX);

      // reset in the middle of operation
      @(posedge clk); #1 rst = 1'b1; inst_f = JAL1;
      @(posedge clk); #1 rst = 1'b0; inst_f = ADDI1;
      @(negedge clk); #1;
      check("rr_inst_x", inst_x, NOP);
      check("rr_inst_w", inst_w, NOP);
      check("rr_bubble", bubble_cnt, 0);
      cyc(ADDI1, 0, 0);
      check("rr_c1_inst_x", inst_x, ADDI1);
      check("rr_c1_bubble", bubble_cnt, 1);

      @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
